// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte FIFO feeding an async-frame serialiser with fractional baud divisor,
// reporting FIFO level/full/empty, busy and overrun status.
module uart_tx_serializer #(
    parameter int DEPTH = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLOCK,
    input  logic                  RESETn,
    input  logic [7:0]            DATA_IN,
    input  logic                  DATA_STROBE,
    input  logic [15:0]           IBRD,
    input  logic [5:0]            FBRD,
    input  logic [1:0]            WLEN,
    input  logic                  PEN,
    input  logic                  EPS,
    input  logic                  STP2,
    input  logic                  UARTEN,
    input  logic                  TXE,
    output logic                  TXD,
    output logic                  TXFF,
    output logic                  TXFE,
    output logic                  BUSY,
    output logic                  OVERRUN,
    output logic [DEPTH_LOG2:0]   LEVEL
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    state_t state, stateNext;
    logic [7:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
    logic [DEPTH_LOG2:0] level;
    logic [7:0] txData, dataMask;
    logic [1:0] wlen;
    logic pen, eps, stp2;
    logic [15:0] pInt, reloadP;
    logic [5:0] fDiv, acc;
    logic [6:0] accSum;
    logic [16:0] cnt;
    logic [4:0] tickCnt;
    logic [2:0] bitIdx, lastIdx;
    logic txd, txdNext, tick, bitEnd, pop, push, full, parityBit;

    assign full = level == FULL_LEVEL;
    assign push = DATA_STROBE && !full;
    assign tick = state != IDLE && cnt == 17'd1;
    assign bitEnd = tick && tickCnt == ((state == STOP && stp2) ? 5'd31 : 5'd15);
    // A new frame may start from IDLE or on the very edge the previous stop bit ends.
    assign pop = level != '0 && UARTEN && TXE && IBRD != '0 && (state == IDLE || (state == STOP && bitEnd));
    assign accSum = {1'b0, acc} + {1'b0, pop ? FBRD : fDiv};
    assign reloadP = pop ? IBRD : pInt;
    assign dataMask = 8'hFF >> (2'd3 - wlen);
    assign lastIdx = {1'b0, wlen} + 3'd4;
    assign parityBit = (^(txData & dataMask)) ^ ~eps;

    always_comb begin
        stateNext = state;
        txdNext = txd;
        case (state)
            IDLE: begin
                stateNext = pop ? START : IDLE;
                txdNext = !pop;
            end
            START: if (bitEnd) begin
                stateNext = DATA;
                txdNext = txData[0];
            end
            DATA: if (bitEnd) begin
                if (bitIdx == lastIdx) begin
                    stateNext = pen ? PARITY : STOP;
                    txdNext = pen ? parityBit : 1'b1;
                end else begin
                    txdNext = txData[bitIdx + 3'd1];
                end
            end
            PARITY: if (bitEnd) begin
                stateNext = STOP;
                txdNext = 1'b1;
            end
            STOP: if (bitEnd) begin
                stateNext = pop ? START : IDLE;
                txdNext = !pop;
            end
            default: begin
                stateNext = IDLE;
                txdNext = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (push) mem[wrPtr] <= DATA_IN;
    end

    always_ff @(posedge CLOCK) begin
        if (!RESETn) begin
            state <= IDLE;
            txd <= 1'b1;
            OVERRUN <= 1'b0;
            level <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
            acc <= '0;
            cnt <= '0;
            tickCnt <= '0;
            bitIdx <= '0;
            txData <= '0;
            wlen <= '0;
            pen <= 1'b0;
            eps <= 1'b0;
            stp2 <= 1'b0;
            pInt <= '0;
            fDiv <= '0;
        end else begin
            state <= stateNext;
            txd <= txdNext;
            OVERRUN <= DATA_STROBE && full;
            level <= level + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            if (pop || tick) begin
                acc <= accSum[5:0];
                cnt <= {1'b0, reloadP} + 17'(accSum[6]);
            end else if (state != IDLE) begin
                cnt <= cnt - 17'd1;
            end
            if (pop) begin
                txData <= mem[rdPtr];
                wlen <= WLEN;
                pen <= PEN;
                eps <= EPS;
                stp2 <= STP2;
                pInt <= IBRD;
                fDiv <= FBRD;
                tickCnt <= '0;
                bitIdx <= '0;
            end else if (tick) begin
                tickCnt <= bitEnd ? 5'd0 : tickCnt + 5'd1;
                if (bitEnd && state == DATA) bitIdx <= bitIdx + 3'd1;
            end
        end
    end

    assign TXD = txd;
    assign TXFF = full;
    assign TXFE = level == '0;
    assign BUSY = state != IDLE || level != '0;
    assign LEVEL = level;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed stimulus with a frame-decoding monitor that pops expected
// frames from a scoreboard queue, plus frame-length and status checks.
module tb_uart_tx_serializer;
    localparam int DL = 4;

    logic CLOCK = 1'b0, RESETn = 1'b0, DATA_STROBE = 1'b0;
    logic PEN = 1'b0, EPS = 1'b0, STP2 = 1'b0, UARTEN = 1'b1, TXE = 1'b1;
    logic [7:0] DATA_IN = '0;
    logic [15:0] IBRD = 16'd1;
    logic [5:0] FBRD = '0;
    logic [1:0] WLEN = 2'd3;
    logic TXD, TXFF, TXFE, BUSY, OVERRUN;
    logic [DL:0] LEVEL;

    int nCmp = 0, nFail = 0, ovCnt = 0, cyc;
    bit monEn = 1'b1;

    typedef struct {
        logic [11:0] bits;
        int nb;
        int per;
    } exp_t;
    exp_t q[$];
    exp_t me;
    logic [11:0] got;

    uart_tx_serializer #(.DEPTH(16), .DEPTH_LOG2(DL)) dut (
        .CLOCK(CLOCK), .RESETn(RESETn), .DATA_IN(DATA_IN), .DATA_STROBE(DATA_STROBE),
        .IBRD(IBRD), .FBRD(FBRD), .WLEN(WLEN), .PEN(PEN), .EPS(EPS), .STP2(STP2),
        .UARTEN(UARTEN), .TXE(TXE), .TXD(TXD), .TXFF(TXFF), .TXFE(TXFE), .BUSY(BUSY),
        .OVERRUN(OVERRUN), .LEVEL(LEVEL)
    );

    always #5 CLOCK = ~CLOCK;

    always @(negedge CLOCK) if (OVERRUN === 1'b1) ovCnt++;

    task automatic check(input string name, input int act, input int exp, input int tol);
        nCmp++;
        if (act < exp - tol || act > exp + tol) begin
            nFail++;
            $display("FAIL %s: got 0x%0h want 0x%0h (tol %0d)", name, act, exp, tol);
        end
    endtask

    // Strobe one byte; when queued, push the expected line bits (start, data LSB first, parity, stops).
    task automatic send(input logic [7:0] b, input bit queued);
        exp_t e;
        int k;
        logic par;
        DATA_IN = b;
        DATA_STROBE = 1'b1;
        @(negedge CLOCK);
        DATA_STROBE = 1'b0;
        if (queued) begin
            e.bits = '0;
            k = 1;
            par = 1'b0;
            for (int i = 0; i < 5 + int'(WLEN); i++) begin
                e.bits[k] = b[i];
                par ^= b[i];
                k++;
            end
            if (PEN) begin
                e.bits[k] = EPS ? par : ~par;
                k++;
            end
            e.bits[k] = 1'b1;
            k++;
            if (STP2) begin
                e.bits[k] = 1'b1;
                k++;
            end
            e.nb = k;
            e.per = 16 * int'(IBRD) + int'(FBRD) / 4;
            q.push_back(e);
        end
    endtask

    // Cycles from the first start-bit cycle until BUSY drops.
    task automatic measure(output int c);
        int t = 0;
        c = 0;
        while (TXD !== 1'b0 && t < 200) begin
            @(negedge CLOCK);
            t++;
        end
        if (TXD !== 1'b0) check("start_timeout", int'(TXD), 0, 0);
        while (BUSY === 1'b1 && c < 4000) begin
            c++;
            @(negedge CLOCK);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLOCK);
            if (monEn && RESETn && TXD === 1'b0) begin
                if (q.size() == 0) begin
                    check("unexpected_frame", 1, 0, 0);
                    repeat (15) @(negedge CLOCK);
                end else begin
                    me = q.pop_front();
                    got = '0;
                    repeat (me.per / 2) @(negedge CLOCK);
                    got[0] = TXD;
                    for (int i = 1; i < me.nb; i++) begin
                        repeat (me.per) @(negedge CLOCK);
                        got[i] = TXD;
                    end
                    repeat (me.per - me.per / 2 - 1) @(negedge CLOCK);
                    check("frame_bits", int'(got), int'(me.bits), 0);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge CLOCK);
        check("rst_txd", int'(TXD), 1, 0);
        check("rst_txff", int'(TXFF), 0, 0);
        check("rst_txfe", int'(TXFE), 1, 0);
        check("rst_busy", int'(BUSY), 0, 0);
        check("rst_overrun", int'(OVERRUN), 0, 0);
        check("rst_level", int'(LEVEL), 0, 0);
        RESETn = 1'b1;
        @(negedge CLOCK);

        send(8'h55, 1'b1);
        measure(cyc);
        check("len_8n1", cyc, 160, 0);
        check("idle_busy", int'(BUSY), 0, 0);
        check("idle_txfe", int'(TXFE), 1, 0);

        PEN = 1'b1; EPS = 1'b1; STP2 = 1'b1;
        send(8'h07, 1'b1);
        measure(cyc);
        check("len_8e2", cyc, 192, 0);

        PEN = 1'b0; STP2 = 1'b0; WLEN = 2'd0;
        send(8'hFF, 1'b1);
        measure(cyc);
        check("len_5n1", cyc, 112, 0);

        WLEN = 2'd3; IBRD = 16'd2; FBRD = 6'd32;
        send(8'hA3, 1'b1);
        measure(cyc);
        check("len_frac", cyc, 400, 1);

        IBRD = 16'd1; FBRD = 6'd0; TXE = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send(8'(i * 37 + 1), i < 16);
            if (i == 15) begin
                check("full_level", int'(LEVEL), 16, 0);
                check("full_txff", int'(TXFF), 1, 0);
            end
        end
        repeat (2) @(negedge CLOCK);
        check("overrun_pulses", ovCnt, 1, 0);
        check("overrun_level", int'(LEVEL), 16, 0);
        TXE = 1'b1;
        measure(cyc);
        check("len_burst16", cyc, 2560, 0);
        check("burst_txfe", int'(TXFE), 1, 0);

        monEn = 1'b0;
        send(8'h3C, 1'b0);
        send(8'hC3, 1'b0);
        repeat (40) @(negedge CLOCK);
        RESETn = 1'b0;
        @(negedge CLOCK);
        check("midrst_txd", int'(TXD), 1, 0);
        check("midrst_level", int'(LEVEL), 0, 0);
        check("midrst_busy", int'(BUSY), 0, 0);
        RESETn = 1'b1;
        @(negedge CLOCK);
        monEn = 1'b1;
        send(8'h96, 1'b1);
        measure(cyc);
        check("len_after_rst", cyc, 160, 0);

        for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge CLOCK);
        check("queue_drained", q.size(), 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
